// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input selecting a - b.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nx;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;
  logic             h1_s;
  logic             h1_c;
  logic             h2_s;
  logic             h2_c;
  logic             c_nx;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1.
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub;
`else
  assign b_ld = b;
  assign c_ld = 1'b0;
`endif

  // Two half-adder stages plus the registered carry.
  assign h1_s = op_a[0] ^ op_b[0];
  assign h1_c = op_a[0] & op_b[0];
  assign h2_s = h1_s ^ c;
  assign h2_c = h1_s & c;
  assign c_nx = h1_c | h2_c;

  assign res_nx = {h2_s, res[WIDTH-1:1]};
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_a <= a;
            op_b <= b_ld;
            c    <= c_ld;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          res  <= res_nx;
          op_a <= op_a >> 1;
          op_b <= op_b >> 1;
          c    <= c_nx;
          cnt  <= cnt + CNT_W'(1);
          // Outputs only ever see the completed word.
          if (last) begin
            sum       <= res_nx;
            carry_out <= c_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven vectors plus scoreboard for serial_adder.
// Covers latency, busy width, held results, ignored start and async abort.
module tb_serial_adder;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       co;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_done = 0;
  logic [8:0] sb[$];
  logic [8:0] last_res = '0;
  vec_t       tbl[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard side: pop and compare whenever the DUT reports done.
  always @(negedge clk) begin
    if (done) begin
      logic [8:0] e;
      n_done++;
      if (sb.size() == 0) begin
        chk("spurious_done", int'(done), 0);
      end else begin
        e = sb.pop_front();
        chk("result", int'({carry_out, sum}), int'(e));
        last_res = e;
      end
    end
  end

  task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                        input logic vs, input logic [8:0] exp,
                        input int inj);
    int lat;
    int bc;
    @(negedge clk);
    a     = va;
    b     = vb;
    sub   = vs;
    start = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    sub   = 1'($urandom);
    lat   = 0;
    bc    = busy ? 1 : 0;
    for (int e = 1; e <= WIDTH + 3; e++) begin
      @(posedge clk);
      #1;
      if (inj != 0 && e == inj) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = e;
        break;
      end
      if (busy) begin
        bc++;
        chk("held", int'({carry_out, sum}), int'(last_res));
      end
    end
    start = 1'b0;
    chk("latency", lat, WIDTH);
    chk("busy_cycles", bc, WIDTH);
    @(posedge clk);
    #1;
    chk("done_pulse", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    int n0;
    logic [7:0] ra;
    logic [7:0] rb;

    tbl.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{8'h5A, 8'h25, 1'b0, 8'h7F, 1'b0});
    tbl.push_back('{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1});
    tbl.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0});
    tbl.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
    tbl.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1});
    tbl.push_back('{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0});
    tbl.push_back('{8'h37, 8'h37, 1'b1, 8'h00, 1'b1});
`endif

    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sum", int'(sum), 0);
    chk("rst_co", int'(carry_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    foreach (tbl[i])
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, {tbl[i].co, tbl[i].s}, 0);

    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, 1'b0, {1'b0, ra} + {1'b0, rb}, 0);
    end

    // start during SHIFT must be ignored, with exactly one done
    n0 = n_done;
    run_op(8'h10, 8'h20, 1'b0, 9'h030, 3);
    repeat (WIDTH + 4) @(posedge clk);
    #1;
    chk("one_done", n_done - n0, 1);

    // asynchronous abort mid-SHIFT
    @(negedge clk);
    a     = 8'h0F;
    b     = 8'h01;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_sum", int'(sum), 0);
    chk("abort_co", int'(carry_out), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    last_res = '0;
    @(negedge clk);
    reset = 1'b0;
    n0 = n_done;
    repeat (WIDTH + 4) @(posedge clk);
    #1;
    chk("no_done_after_abort", n_done - n0, 0);
    run_op(8'h0F, 8'h01, 1'b0, 9'h010, 0);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
